// File: rtl/rtp_depacketizer_if.sv
// rtp_depacketizer_if
//   Bundles the UDP receive byte stream, the DAC sample handshake and the
//   status outputs of rtp_depacketizer.
//   master : the environment side (drives UDP bytes and wav_rden)
//   slave  : the depacketizer side (drives samples and status)
//   Signals:
//     udp_rec_data_valid / udp_rec_rdata / udp_rec_data_length : payload byte stream
//     wav_rden / wav_out_data / wav_out_valid                   : sample pop handshake
//     fifo_level, last_seq, pkt_drop_cnt, seq_gap_cnt,
//     ovf_cnt, unf_cnt                                          : status
interface rtp_depacketizer_if #(
  parameter int FIFO_AW = 10
) ();
  logic                 udp_rec_data_valid;
  logic [7:0]           udp_rec_rdata;
  logic [15:0]          udp_rec_data_length;
  logic                 wav_rden;
  logic signed [15:0]   wav_out_data;
  logic                 wav_out_valid;
  logic [FIFO_AW:0]     fifo_level;
  logic [15:0]          last_seq;
  logic [15:0]          pkt_drop_cnt;
  logic [15:0]          seq_gap_cnt;
  logic [15:0]          ovf_cnt;
  logic [15:0]          unf_cnt;

  modport master (
    output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, wav_rden,
    input  wav_out_data, wav_out_valid, fifo_level, last_seq,
           pkt_drop_cnt, seq_gap_cnt, ovf_cnt, unf_cnt
  );

  modport slave (
    input  udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, wav_rden,
    output wav_out_data, wav_out_valid, fifo_level, last_seq,
           pkt_drop_cnt, seq_gap_cnt, ovf_cnt, unf_cnt
  );
endinterface

// File: rtl/rtp_depacketizer.sv
// rtp_depacketizer
//   Parses RTP packets (12-byte header, big-endian 16-bit PCM) arriving as UDP
//   payload bytes, validates the header, tracks sequence continuity and queues
//   samples in a first-word-fall-through FIFO for the DAC path.
//   Ports:
//     clk   : single clock
//     rst_n : synchronous reset, active HIGH despite the name
//     bus   : rtp_depacketizer_if.slave (byte stream in, samples and status out)
//   Optional feature macro: RTP_JITTER_PRIME_EN
//     defined   -> wav_out_valid held low after reset / underrun until the FIFO
//                  holds at least half its depth
//     undefined -> wav_out_valid follows the FIFO head register
module rtp_depacketizer #(
  parameter logic [7:0]  RTP_HDR_BYTE0 = 8'h80,
  parameter logic [6:0]  PAYLOAD_TYPE  = 7'd0,
  parameter logic [31:0] SSRC          = 32'h12345678,
  parameter int          FIFO_AW       = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rtp_depacketizer_if.slave      bus
);

  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_DISCARD} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             r_state;
  logic               r_prev_vld;
  logic [15:0]        r_len;
  logic [15:0]        r_byte_cnt;
  logic               r_hdr_bad;
  logic [15:0]        r_seq;
  logic [15:0]        r_last_seq;
  logic               r_have_seq;
  logic [7:0]         r_hi;
  logic [15:0]        r_drop_cnt;
  logic [15:0]        r_gap_cnt;
  logic [15:0]        r_ovf_cnt;
  logic [15:0]        r_unf_cnt;

  logic               r_wr_vld_p0;
  logic signed [15:0] r_wr_data_p0;
  logic signed [15:0] r_mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_out_vld_p1;
  logic signed [15:0] r_out_data_p1;

  logic               w_vld;
  logic [7:0]         w_byte;
  logic               w_start;
  logic               w_bad0;
  logic               w_byte_bad;
  logic [15:0]        w_seq_next;
  logic               w_show;
  logic               w_pop;
  logic               w_wr_ok;
  logic               w_load;
  logic [FIFO_AW:0]   w_mem_cnt;

  assign w_vld      = bus.udp_rec_data_valid;
  assign w_byte     = bus.udp_rec_rdata;
  assign w_start    = w_vld & ~r_prev_vld;
  assign w_seq_next = r_last_seq + 16'd1;
  // Byte 0 checks also cover the length field, which is only valid on this byte.
  assign w_bad0     = (w_byte != RTP_HDR_BYTE0) | (bus.udp_rec_data_length < 16'd12) |
                      bus.udp_rec_data_length[0];

  always_comb begin
    w_byte_bad = 1'b0;
    case (r_byte_cnt)
      16'd1:   w_byte_bad = (w_byte[6:0] != PAYLOAD_TYPE);
      16'd8:   w_byte_bad = (w_byte != SSRC[31:24]);
      16'd9:   w_byte_bad = (w_byte != SSRC[23:16]);
      16'd10:  w_byte_bad = (w_byte != SSRC[15:8]);
      16'd11:  w_byte_bad = (w_byte != SSRC[7:0]);
      default: w_byte_bad = 1'b0;
    endcase
  end

  // Stage p0: packet parser; a completed sample is staged for the FIFO write.
  always_ff @(posedge clk) begin
    r_wr_vld_p0 <= 1'b0;
    if (rst_n) begin
      r_state    <= S_IDLE;
      r_prev_vld <= 1'b1;
      r_byte_cnt <= 16'd0;
      r_hdr_bad  <= 1'b0;
      r_have_seq <= 1'b0;
      r_last_seq <= 16'd0;
      r_drop_cnt <= 16'd0;
      r_gap_cnt  <= 16'd0;
    end else begin
      r_prev_vld <= w_vld;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_len      <= bus.udp_rec_data_length;
            r_byte_cnt <= 16'd1;
            r_hdr_bad  <= w_bad0;
            r_state    <= S_HEADER;
          end else if (w_vld) begin
            // Bytes past the declared length, or a packet caught mid-flight at reset.
            r_state <= S_DISCARD;
          end
        end
        S_HEADER: begin
          if (!w_vld) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
            r_state    <= S_IDLE;
          end else begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
            if (r_byte_cnt == 16'd2) r_seq[15:8] <= w_byte;
            if (r_byte_cnt == 16'd3) r_seq[7:0]  <= w_byte;
            if (r_byte_cnt == 16'd11) begin
              if (r_hdr_bad | w_byte_bad) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
                r_state    <= S_DISCARD;
              end else begin
                if (r_have_seq && (r_seq != w_seq_next)) r_gap_cnt <= sat_inc(r_gap_cnt);
                r_last_seq <= r_seq;
                r_have_seq <= 1'b1;
                r_state    <= (r_len == 16'd12) ? S_IDLE : S_PAYLOAD;
              end
            end else begin
              r_hdr_bad <= r_hdr_bad | w_byte_bad;
            end
          end
        end
        S_PAYLOAD: begin
          if (!w_vld) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
            r_state    <= S_IDLE;
          end else begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
            // Payload starts at byte 12 (even), so byte_cnt parity selects high/low byte.
            if (!r_byte_cnt[0]) begin
              r_hi <= w_byte;
            end else begin
              r_wr_vld_p0  <= 1'b1;
              r_wr_data_p0 <= $signed({r_hi, w_byte});
            end
            if (r_byte_cnt == r_len - 16'd1) r_state <= S_IDLE;
          end
        end
        default: begin
          if (!w_vld) r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RTP_JITTER_PRIME_EN
  localparam logic [FIFO_AW:0] HALF = DEPTH >> 1;
  logic r_primed;

  assign w_show = r_out_vld_p1 & r_primed;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_primed <= 1'b0;
    end else if ((w_pop && (r_level == 1) && !w_wr_ok) || (bus.wav_rden && (r_level == 0))) begin
      r_primed <= 1'b0;
    end else if (r_level >= HALF) begin
      r_primed <= 1'b1;
    end
  end
`else
  assign w_show = r_out_vld_p1;
`endif

  assign w_pop     = bus.wav_rden & w_show;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign w_wr_ok   = r_wr_vld_p0 & ((r_level != DEPTH) | w_pop);
  assign w_mem_cnt = r_level - {{FIFO_AW{1'b0}}, r_out_vld_p1};
  assign w_load    = (w_mem_cnt != 0) & (~r_out_vld_p1 | w_pop);

  // Stage p1: FIFO storage and head register (FIFO memory holds all but the head sample).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_out_vld_p1 <= 1'b0;
      r_ovf_cnt    <= 16'd0;
      r_unf_cnt    <= 16'd0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_wr_vld_p0 && !w_wr_ok) r_ovf_cnt <= sat_inc(r_ovf_cnt);
      if (bus.wav_rden && !w_show) r_unf_cnt <= sat_inc(r_unf_cnt);
      r_level <= r_level + {{FIFO_AW{1'b0}}, w_wr_ok} - {{FIFO_AW{1'b0}}, w_pop};
      if (w_load) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_out_vld_p1 <= 1'b1;
      end else if (w_pop) begin
        r_out_vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= r_wr_data_p0;
    if (w_load)  r_out_data_p1   <= r_mem[r_rd_ptr];
  end

  assign bus.wav_out_valid = w_show;
  assign bus.wav_out_data  = w_show ? r_out_data_p1 : 16'sd0;
  assign bus.fifo_level    = r_level;
  assign bus.last_seq      = r_last_seq;
  assign bus.pkt_drop_cnt  = r_drop_cnt;
  assign bus.seq_gap_cnt   = r_gap_cnt;
  assign bus.ovf_cnt       = r_ovf_cnt;
  assign bus.unf_cnt       = r_unf_cnt;

endmodule
